// File: rtl/cpu_run_monitor_if.sv
// Handshake/observation bundle between a run host and cpu_run_monitor.
// Trace signals exist only when CPU_MON_TRACE_EN is defined.
interface cpu_run_monitor_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             start;
    logic [XLEN-1:0]  pc_;
    logic [XLEN-1:0]  data;
    logic             cpu_rstn;
    logic             busy;
    logic             done;
    logic             halted;
    logic             timeout;
    logic [CNT_W-1:0] cycles;
    logic [XLEN-1:0]  result;
    logic [XLEN-1:0]  halt_pc;
`ifdef CPU_MON_TRACE_EN
    logic [2:0]       trace_idx;
    logic [XLEN-1:0]  trace_pc;
    logic [3:0]       trace_cnt;

    modport master (
        output start, pc_, data, trace_idx,
        input  cpu_rstn, busy, done, halted, timeout,
        input  cycles, result, halt_pc, trace_pc, trace_cnt
    );
    modport slave (
        input  start, pc_, data, trace_idx,
        output cpu_rstn, busy, done, halted, timeout,
        output cycles, result, halt_pc, trace_pc, trace_cnt
    );
`else
    modport master (
        output start, pc_, data,
        input  cpu_rstn, busy, done, halted, timeout,
        input  cycles, result, halt_pc
    );
    modport slave (
        input  start, pc_, data,
        output cpu_rstn, busy, done, halted, timeout,
        output cycles, result, halt_pc
    );
`endif
endinterface

// File: rtl/cpu_run_monitor.sv
// CPU reset sequencer, jump-to-self halt / timeout detector, result capture.
// Define CPU_MON_TRACE_EN to add an 8-entry PC change trace ring.
module cpu_run_monitor #(
    parameter int XLEN        = 32,
    parameter int CNT_W       = 32,
    parameter int RST_CYCLES  = 2,
    parameter int HALT_REPEAT = 4,
    parameter int MAX_CYCLES  = 20
) (
    input  logic             clk,
    input  logic             rst,
    cpu_run_monitor_if.slave bus
);
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int HW = $clog2(HALT_REPEAT + 1);
    localparam logic [RW-1:0]    RST_LAST = RW'(RST_CYCLES - 1);
    localparam logic [HW-1:0]    REP_MAX  = HW'(HALT_REPEAT);
    localparam logic [CNT_W-1:0] MAXC     = CNT_W'(MAX_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE, S_RESET, S_RUN, S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
    logic [HW-1:0]    rep_q, rep_d;
    logic [XLEN-1:0]  pc_prev_q, pc_prev_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [XLEN-1:0]  halt_pc_q, halt_pc_d;
    logic             halted_q, halted_d;
    logic             timeout_q, timeout_d;
    logic             cpu_rstn_q, cpu_rstn_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic first, same, start_clr, halt_hit, to_hit;

    // cycles is zero only before the first RUN edge of a run
    assign first     = (cycles_q == '0);
    assign same      = (bus.pc_ == pc_prev_q);
    assign start_clr = bus.start &&
                       (state_q == S_IDLE || state_q == S_DONE);

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        rep_d     = rep_q;
        pc_prev_d = pc_prev_q;
        cycles_d  = cycles_q;
        result_d  = result_q;
        halt_pc_d = halt_pc_q;
        halted_d  = halted_q;
        timeout_d = timeout_q;
        halt_hit  = 1'b0;
        to_hit    = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d   = S_RESET;
                    rst_cnt_d = '0;
                    rep_d     = '0;
                    cycles_d  = '0;
                    halted_d  = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            S_RESET: begin
                rst_cnt_d = rst_cnt_q + RW'(1);
                if (rst_cnt_q == RST_LAST)
                    state_d = S_RUN;
            end
            S_RUN: begin
                if (cycles_q != '1)
                    cycles_d = cycles_q + CNT_W'(1);
                pc_prev_d = bus.pc_;
                if (first || !same)
                    rep_d = '0;
                else if (rep_q != REP_MAX)
                    rep_d = rep_q + HW'(1);
                halt_hit = (rep_d == REP_MAX);
                to_hit   = (MAX_CYCLES != 0) && (cycles_d == MAXC);
                if (halt_hit || to_hit) begin
                    state_d   = S_DONE;
                    halted_d  = halt_hit;
                    timeout_d = !halt_hit;
                    result_d  = bus.data;
                    halt_pc_d = bus.pc_;
                end
            end
            default: state_d = S_IDLE;
        endcase
        cpu_rstn_d = (state_d == S_RUN) || (state_d == S_DONE);
        busy_d     = (state_d == S_RESET) || (state_d == S_RUN);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rst_cnt_q  <= '0;
            rep_q      <= '0;
            pc_prev_q  <= '0;
            cycles_q   <= '0;
            result_q   <= '0;
            halt_pc_q  <= '0;
            halted_q   <= 1'b0;
            timeout_q  <= 1'b0;
            cpu_rstn_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            rep_q      <= rep_d;
            pc_prev_q  <= pc_prev_d;
            cycles_q   <= cycles_d;
            result_q   <= result_d;
            halt_pc_q  <= halt_pc_d;
            halted_q   <= halted_d;
            timeout_q  <= timeout_d;
            cpu_rstn_q <= cpu_rstn_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.cpu_rstn = cpu_rstn_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.halted   = halted_q;
    assign bus.timeout  = timeout_q;
    assign bus.cycles   = cycles_q;
    assign bus.result   = result_q;
    assign bus.halt_pc  = halt_pc_q;

`ifdef CPU_MON_TRACE_EN
    logic [XLEN-1:0] trace_q [8];
    logic [2:0]      wp_q;
    logic [3:0]      tcnt_q;
    logic [2:0]      rd_idx;
    logic            push;

    assign push = (state_q == S_RUN) && (first || !same);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) trace_q[i] <= '0;
            wp_q   <= '0;
            tcnt_q <= '0;
        end else if (start_clr) begin
            for (int i = 0; i < 8; i++) trace_q[i] <= '0;
            wp_q   <= '0;
            tcnt_q <= '0;
        end else if (push) begin
            trace_q[wp_q] <= bus.pc_;
            wp_q          <= wp_q + 3'd1;
            if (tcnt_q != 4'd8)
                tcnt_q <= tcnt_q + 4'd1;
        end
    end

    // index 0 is the entry just behind the write pointer
    assign rd_idx        = wp_q - 3'd1 - bus.trace_idx;
    assign bus.trace_pc  = trace_q[rd_idx];
    assign bus.trace_cnt = tcnt_q;
`else
    logic unused_clr;
    assign unused_clr = start_clr;
`endif
endmodule

// File: tb/tb_cpu_run_monitor.sv
// Scoreboard bench for cpu_run_monitor: directed and random PC traces,
// expected completions queued by a window-based model, popped on done.
module tb_cpu_run_monitor;
    localparam int XLEN        = 32;
    localparam int CNT_W       = 32;
    localparam int RST_CYCLES  = 2;
    localparam int HALT_REPEAT = 4;
    localparam int MAX_CYCLES  = 20;
    localparam int NPLAN       = 40;

    typedef struct {
        logic        h;
        logic        t;
        logic [31:0] res;
        logic [31:0] hpc;
        logic [31:0] cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] plan [NPLAN];
    logic [31:0] dat  [NPLAN];
    exp_t        sb[$];
    logic [31:0] last_res, last_hpc;

    cpu_run_monitor_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    cpu_run_monitor #(
        .XLEN(XLEN), .CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES),
        .HALT_REPEAT(HALT_REPEAT), .MAX_CYCLES(MAX_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act,
                                logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // Run ends at the first cycle whose PC equals the previous
    // HALT_REPEAT samples of this run, or at MAX_CYCLES.
    function automatic exp_t model();
        exp_t e;
        e.h = 0; e.t = 0; e.res = 0; e.hpc = 0; e.cyc = 0;
        for (int k = 0; k < NPLAN; k++) begin
            bit hit = (k >= HALT_REPEAT);
            for (int j = 1; j <= HALT_REPEAT && hit; j++)
                if (plan[k-j] != plan[k]) hit = 0;
            if (hit || (MAX_CYCLES != 0 && k + 1 == MAX_CYCLES)) begin
                e.h = hit; e.t = !hit;
                e.res = dat[k]; e.hpc = plan[k]; e.cyc = k + 1;
                return e;
            end
        end
        return e;
    endfunction

    task automatic run(input int abort_at, input int sk);
        exp_t e;
        bit   seen;
        e = model();
        if (abort_at < 0) sb.push_back(e);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_busy", bus.busy, 1);
        chk("start_rstn", bus.cpu_rstn, 0);
        chk("start_done", bus.done, 0);
        chk("start_halted", bus.halted, 0);
        chk("start_timeout", bus.timeout, 0);
        chk("start_cycles", bus.cycles, 0);
        chk("hold_result", bus.result, last_res);
        chk("hold_halt_pc", bus.halt_pc, last_hpc);
        repeat (RST_CYCLES - 1) begin
            @(negedge clk);
            chk("reset_rstn", bus.cpu_rstn, 0);
        end
        @(negedge clk);
        chk("run_rstn", bus.cpu_rstn, 1);
        chk("run_busy", bus.busy, 1);
        seen = 0;
        for (int k = 0; k < NPLAN && !seen; k++) begin
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                chk("arst_rstn", bus.cpu_rstn, 0);
                chk("arst_busy", bus.busy, 0);
                chk("arst_cycles", bus.cycles, 0);
                chk("arst_result", bus.result, 0);
                chk("arst_halt_pc", bus.halt_pc, 0);
                chk("arst_flags",
                    {bus.done, bus.halted, bus.timeout}, 0);
                @(negedge clk);
                rst = 1'b0;
                last_res = 0;
                last_hpc = 0;
                return;
            end
            bus.pc_   = plan[k];
            bus.data  = dat[k];
            bus.start = (k == sk);
            @(negedge clk);
            seen = bus.done;
        end
        bus.start = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL run_end actual=no_done required=done");
        end
        last_res = e.res;
        last_hpc = e.hpc;
    endtask

    task automatic gen_random();
        int idx = 0;
        while (idx < NPLAN) begin
            logic [31:0] v = $urandom_range(0, 7) * 4;
            int len = $urandom_range(1, 6);
            for (int i = 0; i < len && idx < NPLAN; i++) begin
                plan[idx] = v;
                idx++;
            end
        end
        for (int i = 0; i < NPLAN; i++) dat[i] = $urandom;
    endtask

    initial begin : monitor
        exp_t e;
        logic done_prev;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.done && !done_prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty actual=done required=none");
                end else begin
                    e = sb.pop_front();
                    chk("halted", bus.halted, e.h);
                    chk("timeout", bus.timeout, e.t);
                    chk("result", bus.result, e.res);
                    chk("halt_pc", bus.halt_pc, e.hpc);
                    chk("cycles", bus.cycles, e.cyc);
                    chk("done_busy", bus.busy, 0);
                    chk("done_rstn", bus.cpu_rstn, 1);
                end
            end
            done_prev = bus.done;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog actual=hung required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        bus.start = 1'b0;
        bus.pc_   = '0;
        bus.data  = '0;
`ifdef CPU_MON_TRACE_EN
        bus.trace_idx = '0;
`endif
        last_res = 0;
        last_hpc = 0;
        @(negedge clk);
        chk("rst_rstn", bus.cpu_rstn, 0);
        chk("rst_outs", {bus.busy, bus.done, bus.halted, bus.timeout}, 0);
        chk("rst_cycles", bus.cycles, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_halt_pc", bus.halt_pc, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", bus.busy, 0);

        // halt: 0,4,8,12 then 12 held, data 55
        for (int i = 0; i < NPLAN; i++) begin
            plan[i] = (i < 4) ? i * 4 : 12;
            dat[i]  = 55;
        end
        run(-1, -1);

        // timeout: pc advances every cycle
        for (int i = 0; i < NPLAN; i++) begin
            plan[i] = i * 4;
            dat[i]  = $urandom;
        end
        run(-1, 3);

        // halt completes on the same edge as the cycle limit
        for (int i = 0; i < NPLAN; i++) begin
            plan[i] = (i < 16) ? i * 4 : 60;
            dat[i]  = $urandom;
        end
        run(-1, -1);

        // 11 distinct PCs then a self-loop at 40
        for (int i = 0; i < NPLAN; i++) begin
            plan[i] = (i < 11) ? i * 4 : 40;
            dat[i]  = $urandom;
        end
        run(-1, -1);
`ifdef CPU_MON_TRACE_EN
        bus.trace_idx = 3'd0;
        #1 chk("trace_idx0", bus.trace_pc, 40);
        bus.trace_idx = 3'd7;
        #1 chk("trace_idx7", bus.trace_pc, 12);
        chk("trace_cnt", bus.trace_cnt, 8);
        bus.trace_idx = 3'd0;
`endif

        gen_random();
        run(5, -1);
        repeat (2) @(negedge clk);
        chk("post_arst_done", bus.done, 0);

        for (int r = 0; r < 12; r++) begin
            gen_random();
            run(-1, $urandom_range(0, 30));
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
